// File: rtl/per_req_arbiter_rr.sv
// Per-slave request arbiter: round-robin selection with lock-until-grant, plus an
// in-order ID FIFO that routes each slave response back to the master that issued it.
module per_req_arbiter_rr #(
   parameter int N_MASTER        = 16,
   parameter int ID_WIDTH        = N_MASTER,
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int BE_WIDTH        = DATA_WIDTH/8,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [N_MASTER-1:0]            data_req_i,
   input  logic [N_MASTER*ADDR_WIDTH-1:0] data_add_i,
   input  logic [N_MASTER-1:0]            data_wen_i,
   input  logic [N_MASTER*DATA_WIDTH-1:0] data_wdata_i,
   input  logic [N_MASTER*BE_WIDTH-1:0]   data_be_i,
   input  logic [N_MASTER*ID_WIDTH-1:0]   data_ID_i,
   output logic [N_MASTER-1:0]            data_gnt_o,
   output logic                           data_req_o,
   output logic [ADDR_WIDTH-1:0]          data_add_o,
   output logic                           data_wen_o,
   output logic [DATA_WIDTH-1:0]          data_wdata_o,
   output logic [BE_WIDTH-1:0]            data_be_o,
   output logic [ID_WIDTH-1:0]            data_ID_o,
   input  logic                           data_gnt_i,
   input  logic                           data_r_valid_i,
   input  logic [DATA_WIDTH-1:0]          data_r_rdata_i,
   output logic [N_MASTER-1:0]            data_r_valid_o,
   output logic [DATA_WIDTH-1:0]          data_r_rdata_o
);

   localparam int IDX_W = $clog2(N_MASTER);
   localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

   logic [IDX_W-1:0]    r_rr;
   logic                r_lock;
   logic [IDX_W-1:0]    r_lock_idx;
   logic [ID_WIDTH-1:0] r_fifo [MAX_OUTSTANDING];
   logic [PTR_W-1:0]    r_wr_ptr;
   logic [PTR_W-1:0]    r_rd_ptr;
   logic [CNT_W-1:0]    r_count;

   logic [IDX_W-1:0]             w_rr_idx;
   logic                         w_rr_found;
   logic                         w_lock_hit;
   logic [IDX_W-1:0]             w_winner;
   logic [IDX_W-1:0]             w_next_rr;
   int                           w_sel;
   logic                         w_any;
   logic                         w_full;
   logic                         w_empty;
   logic                         w_handshake;
   logic                         w_stall;
   logic                         w_pop;
   logic [N_MASTER+ID_WIDTH-1:0] w_head_pad;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
   endfunction

   // First requester at or after r_rr, wrapping past N_MASTER-1.
   always_comb begin
      w_rr_idx   = '0;
      w_rr_found = 1'b0;
      for (int k = 0; k < N_MASTER; k++) begin
         if (!w_rr_found && data_req_i[(int'(r_rr) + k) % N_MASTER]) begin
            w_rr_found = 1'b1;
            w_rr_idx   = IDX_W'((int'(r_rr) + k) % N_MASTER);
         end
      end
   end

   // A lock on a master that dropped its request is ignored for this cycle.
   assign w_lock_hit  = r_lock & data_req_i[r_lock_idx];
   assign w_winner    = w_lock_hit ? r_lock_idx : w_rr_idx;
   assign w_next_rr   = (w_winner == IDX_W'(N_MASTER - 1)) ? '0 : w_winner + 1'b1;
   assign w_any       = |data_req_i;
   assign w_full      = (r_count == CNT_W'(MAX_OUTSTANDING));
   assign w_empty     = (r_count == '0);
   assign data_req_o  = w_any & ~w_full & ~rst;
   assign w_handshake = data_req_o & data_gnt_i;
   assign w_stall     = data_req_o & ~data_gnt_i;
   assign w_pop       = data_r_valid_i & ~w_empty & ~rst;

   always_comb begin
      w_sel        = int'(w_winner);
      data_add_o   = '0;
      data_wen_o   = 1'b0;
      data_wdata_o = '0;
      data_be_o    = '0;
      data_ID_o    = '0;
      data_gnt_o   = '0;
      if (w_any) begin
         data_add_o   = data_add_i[w_sel*ADDR_WIDTH +: ADDR_WIDTH];
         data_wen_o   = data_wen_i[w_sel];
         data_wdata_o = data_wdata_i[w_sel*DATA_WIDTH +: DATA_WIDTH];
         data_be_o    = data_be_i[w_sel*BE_WIDTH +: BE_WIDTH];
         data_ID_o    = data_ID_i[w_sel*ID_WIDTH +: ID_WIDTH];
      end
      data_gnt_o[w_sel] = w_handshake;
   end

   // The head ID is a one-hot master mask; pad so any ID_WIDTH maps onto N_MASTER bits.
   assign w_head_pad     = {{N_MASTER{1'b0}}, r_fifo[r_rd_ptr]};
   assign data_r_valid_o = w_head_pad[N_MASTER-1:0] & {N_MASTER{w_pop}};
   assign data_r_rdata_o = data_r_rdata_i;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rr       <= '0;
         r_lock     <= 1'b0;
         r_lock_idx <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
      end else begin
         if (w_handshake) begin
            r_rr   <= w_next_rr;
            r_lock <= 1'b0;
         end else if (w_stall) begin
            r_lock     <= 1'b1;
            r_lock_idx <= w_winner;
         end
         if (w_handshake) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (w_pop)       r_rd_ptr <= ptr_inc(r_rd_ptr);
         if (w_handshake && !w_pop)      r_count <= r_count + 1'b1;
         else if (!w_handshake && w_pop) r_count <= r_count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_handshake) r_fifo[r_wr_ptr] <= data_ID_o;
   end

   always @(posedge clk) begin
      if (!rst && data_r_valid_i) assert (!w_empty) else $warning("response with no outstanding ID");
   end

endmodule

// File: tb/tb_per_req_arbiter_rr.sv
// Bench for per_req_arbiter_rr: directed scenarios plus randomized traffic, all checked
// every cycle against a queue-based reference model of the arbiter.
module tb_per_req_arbiter_rr;

   localparam int N  = 16;
   localparam int IW = N;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int BW = DW/8;
   localparam int MO = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  data_req_i;
   logic [N*AW-1:0] data_add_i;
   logic [N-1:0]  data_wen_i;
   logic [N*DW-1:0] data_wdata_i;
   logic [N*BW-1:0] data_be_i;
   logic [N*IW-1:0] data_ID_i;
   logic [N-1:0]  data_gnt_o;
   logic          data_req_o;
   logic [AW-1:0] data_add_o;
   logic          data_wen_o;
   logic [DW-1:0] data_wdata_o;
   logic [BW-1:0] data_be_o;
   logic [IW-1:0] data_ID_o;
   logic          data_gnt_i;
   logic          data_r_valid_i;
   logic [DW-1:0] data_r_rdata_i;
   logic [N-1:0]  data_r_valid_o;
   logic [DW-1:0] data_r_rdata_o;

   always #5 clk = ~clk;

   per_req_arbiter_rr #(
      .N_MASTER(N), .ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
      .BE_WIDTH(BW), .MAX_OUTSTANDING(MO)
   ) dut (
      .clk(clk), .rst(rst),
      .data_req_i(data_req_i), .data_add_i(data_add_i), .data_wen_i(data_wen_i),
      .data_wdata_i(data_wdata_i), .data_be_i(data_be_i), .data_ID_i(data_ID_i),
      .data_gnt_o(data_gnt_o), .data_req_o(data_req_o), .data_add_o(data_add_o),
      .data_wen_o(data_wen_o), .data_wdata_o(data_wdata_o), .data_be_o(data_be_o),
      .data_ID_o(data_ID_o), .data_gnt_i(data_gnt_i), .data_r_valid_i(data_r_valid_i),
      .data_r_rdata_i(data_r_rdata_i), .data_r_valid_o(data_r_valid_o),
      .data_r_rdata_o(data_r_rdata_o)
   );

   int tests = 0;
   int fails = 0;

   logic [AW-1:0] m_add [N];
   logic          m_wen [N];
   logic [DW-1:0] m_wdata [N];
   logic [BW-1:0] m_be [N];
   logic [IW-1:0] m_id [N];

   // Reference model: rotating priority pointer, lock target, outstanding ID queue.
   int            mdl_rr;
   bit            mdl_lock;
   int            mdl_lock_idx;
   logic [IW-1:0] exp_q[$];

   function automatic logic [N-1:0] oh(input int i);
      logic [N-1:0] v;
      v = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic rand_fields();
      for (int i = 0; i < N; i++) begin
         m_add[i]   = $urandom;
         m_wen[i]   = 1'($urandom_range(0, 1));
         m_wdata[i] = $urandom;
         m_be[i]    = BW'($urandom);
         m_id[i]    = oh(i);
      end
   endtask

   // One clock cycle: drive at negedge, check model against DUT, advance the model.
   task automatic cyc(input logic [N-1:0] req, input logic gi, input logic rv, input logic rs);
      int           w;
      bit           any, full, req_o, hs, pop;
      logic [N-1:0] e_gnt, e_rv;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         data_add_i[i*AW +: AW]   = m_add[i];
         data_wen_i[i]            = m_wen[i];
         data_wdata_i[i*DW +: DW] = m_wdata[i];
         data_be_i[i*BW +: BW]    = m_be[i];
         data_ID_i[i*IW +: IW]    = m_id[i];
      end
      rst            = rs;
      data_req_i     = req;
      data_gnt_i     = gi;
      data_r_valid_i = rv;
      data_r_rdata_i = $urandom;
      if (rs) begin
         mdl_rr = 0; mdl_lock = 0; mdl_lock_idx = 0;
         exp_q.delete();
      end
      #1;
      any = (req != '0);
      w = 0;
      if (mdl_lock && req[mdl_lock_idx]) w = mdl_lock_idx;
      else for (int k = N - 1; k >= 0; k--) if (req[(mdl_rr + k) % N]) w = (mdl_rr + k) % N;
      full  = (exp_q.size() == MO);
      req_o = !rs && any && !full;
      hs    = req_o && gi;
      pop   = !rs && rv && (exp_q.size() > 0);
      e_gnt = hs ? oh(w) : '0;
      e_rv  = pop ? exp_q[0] : '0;
      chk("req_o", 64'(data_req_o), 64'(req_o));
      chk("gnt_o", 64'(data_gnt_o), 64'(e_gnt));
      chk("add_o", 64'(data_add_o), any ? 64'(m_add[w]) : 64'(0));
      chk("wen_o", 64'(data_wen_o), any ? 64'(m_wen[w]) : 64'(0));
      chk("wdata_o", 64'(data_wdata_o), any ? 64'(m_wdata[w]) : 64'(0));
      chk("be_o", 64'(data_be_o), any ? 64'(m_be[w]) : 64'(0));
      chk("id_o", 64'(data_ID_o), any ? 64'(m_id[w]) : 64'(0));
      chk("r_valid_o", 64'(data_r_valid_o), 64'(e_rv));
      chk("r_rdata_o", 64'(data_r_rdata_o), 64'(data_r_rdata_i));
      if (!rs) begin
         if (pop) void'(exp_q.pop_front());
         if (hs) begin
            exp_q.push_back(m_id[w]);
            mdl_rr   = (w + 1) % N;
            mdl_lock = 0;
         end else if (req_o) begin
            mdl_lock     = 1;
            mdl_lock_idx = w;
         end
      end
   endtask

   initial begin
      int seq [6];
      logic [N-1:0] r;
      seq = '{0, 3, 5, 0, 3, 5};
      rst = 1'b1;
      data_req_i = '0; data_add_i = '0; data_wen_i = '0; data_wdata_i = '0;
      data_be_i = '0; data_ID_i = '0; data_gnt_i = 1'b0; data_r_valid_i = 1'b0;
      data_r_rdata_i = '0;
      mdl_rr = 0; mdl_lock = 0; mdl_lock_idx = 0;
      rand_fields();

      // Reset holds the slave request and grants low even with requests present.
      cyc(oh(4) | oh(9), 1'b1, 1'b0, 1'b1);
      chk("reset_req_o", 64'(data_req_o), 64'(0));
      chk("reset_gnt_o", 64'(data_gnt_o), 64'(0));
      cyc('0, 1'b0, 1'b0, 1'b0);

      // Masters 0,3,5 always requesting, slave always granting.
      for (int c = 0; c < 6; c++) begin
         cyc(oh(0) | oh(3) | oh(5), 1'b1, c > 0, 1'b0);
         chk("rr_seq_gnt", 64'(data_gnt_o), 64'(oh(seq[c])));
         chk("rr_seq_id", 64'(data_ID_o), 64'(oh(seq[c])));
      end
      cyc('0, 1'b0, 1'b1, 1'b0);
      chk("rr_seq_drain", 64'(data_r_valid_o), 64'(oh(5)));

      // Lock: master 2 stalled three cycles, master 1 arrives mid-stall.
      cyc(oh(2), 1'b0, 1'b0, 1'b0);
      chk("lock_add_c1", 64'(data_add_o), 64'(m_add[2]));
      cyc(oh(2) | oh(1), 1'b0, 1'b0, 1'b0);
      chk("lock_add_c2", 64'(data_add_o), 64'(m_add[2]));
      cyc(oh(2) | oh(1), 1'b0, 1'b0, 1'b0);
      chk("lock_add_c3", 64'(data_add_o), 64'(m_add[2]));
      cyc(oh(2) | oh(1), 1'b1, 1'b0, 1'b0);
      chk("lock_gnt_c4", 64'(data_gnt_o), 64'(oh(2)));
      cyc(oh(2) | oh(1), 1'b1, 1'b1, 1'b0);
      chk("lock_next_gnt", 64'(data_gnt_o), 64'(oh(1)));
      chk("lock_resp", 64'(data_r_valid_o), 64'(oh(2)));
      cyc('0, 1'b0, 1'b1, 1'b0);

      // FIFO full blocks the request until a response frees a slot.
      cyc(oh(3), 1'b1, 1'b0, 1'b0);
      cyc(oh(6), 1'b1, 1'b0, 1'b0);
      cyc(oh(3) | oh(6), 1'b1, 1'b0, 1'b0);
      chk("full_req_o", 64'(data_req_o), 64'(0));
      chk("full_gnt_o", 64'(data_gnt_o), 64'(0));
      cyc(oh(3) | oh(6), 1'b1, 1'b1, 1'b0);
      chk("full_pop_req_o", 64'(data_req_o), 64'(0));
      chk("full_pop_route", 64'(data_r_valid_o), 64'(oh(3)));
      cyc(oh(3) | oh(6), 1'b1, 1'b0, 1'b0);
      chk("full_reassert", 64'(data_req_o), 64'(1));
      cyc('0, 1'b0, 1'b1, 1'b0);
      cyc('0, 1'b0, 1'b1, 1'b0);

      // Push and pop in the same cycle, then drain to empty and pop once more.
      cyc(oh(4), 1'b1, 1'b0, 1'b0);
      cyc(oh(7), 1'b1, 1'b1, 1'b0);
      chk("pp_gnt", 64'(data_gnt_o), 64'(oh(7)));
      chk("pp_resp0", 64'(data_r_valid_o), 64'(oh(4)));
      cyc('0, 1'b0, 1'b1, 1'b0);
      chk("pp_resp1", 64'(data_r_valid_o), 64'(oh(7)));
      cyc('0, 1'b0, 1'b1, 1'b0);
      chk("empty_pop", 64'(data_r_valid_o), 64'(0));

      // Reset with one ID outstanding and rr away from 0.
      cyc(oh(10), 1'b1, 1'b0, 1'b0);
      cyc(oh(12) | oh(0), 1'b1, 1'b0, 1'b1);
      chk("midrst_gnt", 64'(data_gnt_o), 64'(0));
      cyc('0, 1'b0, 1'b1, 1'b0);
      chk("midrst_resp", 64'(data_r_valid_o), 64'(0));
      cyc(oh(12) | oh(0), 1'b1, 1'b0, 1'b0);
      chk("midrst_first", 64'(data_gnt_o), 64'(oh(0)));
      cyc('0, 1'b0, 1'b1, 1'b0);

      // Randomized traffic.
      r = '0;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 3) == 0) rand_fields();
         if ($urandom_range(0, 2) == 0) r = N'($urandom & $urandom);
         cyc(r, 1'($urandom_range(0, 3) != 0),
             (exp_q.size() > 0) ? 1'($urandom_range(0, 1)) : 1'b0,
             1'($urandom_range(0, 499) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/per_req_arbiter_rr.md
# per_req_arbiter_rr

Per-slave request arbiter of the peripheral interconnect, placed directly downstream of the per-master address decoders. It collects the one-hot request lines that N_MASTER decoders raise for one peripheral slave and selects one master with a round-robin policy and lock-until-grant. It forwards the winner's transaction to the slave and records the winner's ID in an in-order FIFO. When the slave responds, it uses that ID to route `r_valid` and read data back to the issuing master.

## Interface
- N_MASTER, 16: number of requesting masters (≥2, need not be a power of 2)
- ID_WIDTH, N_MASTER: width of the one-hot master ID carried with each request
- ADDR_WIDTH, 32: address width
- DATA_WIDTH, 32: data width
- BE_WIDTH, DATA_WIDTH/8: byte-enable width
- MAX_OUTSTANDING, 2: depth of the response-routing ID FIFO (≥1)

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  asynchronous, active-high reset
- data_req_i  in  N_MASTER  per-master request, from the address decoders
- data_add_i  in  N_MASTER×ADDR_WIDTH  per-master address
- data_wen_i  in  N_MASTER  per-master write enable, active low (0 = write)
- data_wdata_i  in  N_MASTER×DATA_WIDTH  per-master write data
- data_be_i  in  N_MASTER×BE_WIDTH  per-master byte enables
- data_ID_i  in  N_MASTER×ID_WIDTH  per-master one-hot ID
- data_gnt_o  out  N_MASTER  per-master grant
- data_req_o  out  1  request to the slave
- data_add_o  out  ADDR_WIDTH  winner's address
- data_wen_o  out  1  winner's write enable
- data_wdata_o  out  DATA_WIDTH  winner's write data
- data_be_o  out  BE_WIDTH  winner's byte enables
- data_ID_o  out  ID_WIDTH  winner's ID
- data_gnt_i  in  1  grant from the slave
- data_r_valid_i  in  1  response valid from the slave
- data_r_rdata_i  in  DATA_WIDTH  response data from the slave
- data_r_valid_o  out  N_MASTER  per-master response valid
- data_r_rdata_o  out  DATA_WIDTH  response data, broadcast to all masters

## Operation
- State:
  - rr_q: ceil(log2 N_MASTER) bits; reset 0.
  - lock_q (1 bit) and lock_idx_q; reset 0.
  - ID FIFO with count; reset empty.
- Winner selection when lock_q = 0:
  - The winner is the first index i with data_req_i[i] = 1, scanning from rr_q upward and wrapping past N_MASTER-1 to 0.
- Winner selection when lock_q = 1:
  - The winner is lock_idx_q.
  - If data_req_i[lock_idx_q] = 0 (a protocol violation), the lock is ignored and round-robin applies in the same cycle.
- Slave request:
  - data_req_o = (any data_req_i) AND NOT fifo_full.
  - The data, address, wen, be and ID outputs are the winner's fields.
  - When no master requests, these outputs are 0.
- Handshake: occurs when data_req_o AND data_gnt_i. On a handshake:
  - data_gnt_o[winner] = 1; all other grant bits are 0.
  - The winner's ID is pushed into the FIFO.
  - rr_q ← (winner+1) mod N_MASTER.
  - lock_q ← 0.
- Stall: data_req_o AND NOT data_gnt_i sets lock_q ← 1 and lock_idx_q ← winner. Arbitration therefore stays stable until the grant.
- FIFO full: data_req_o = 0, all data_gnt_o = 0, lock state and rr_q hold.
- Response:
  - data_r_valid_o = FIFO head AND replicate(data_r_valid_i).
  - data_r_valid_i pops the head.
  - data_r_rdata_o = data_r_rdata_i unconditionally.
- Push and pop in the same cycle: allowed; the count is unchanged. Full with a pop: the request stays blocked that cycle (full is evaluated on the registered count).
- Pop on an empty FIFO: ignored; data_r_valid_o = 0; the count stays 0 (flagged by a simulation assertion).
- Responses are strictly in grant order.

## Timing
- Request path: combinational, zero latency (req_i to req_o); grant back to master in the same cycle as data_gnt_i.
- The response routing is combinational in the data_r_valid_i cycle.
- A push is visible at the FIFO head from the next cycle. The earliest legal response is the cycle after the grant.
- rr_q and lock updates take effect in the cycle after the handshake or stall.
- While rst = 1: data_req_o, data_gnt_o and data_r_valid_o are forced to 0 and all state is at its reset value.
- Reset asserted mid-transaction: outstanding IDs are discarded. Responses arriving after reset produce no data_r_valid_o.

## Test plan
- Masters 0, 3 and 5 requesting continuously, data_gnt_i = 1 every cycle → grants go 0, 3, 5, 0, 3, 5; data_ID_o follows.
- Master 2 requests, data_gnt_i = 0 for 3 cycles, and master 1 rises in cycle 2 → the winner stays master 2 until the grant in cycle 4; then rr_q = 3 and master 1 wins next.
- MAX_OUTSTANDING = 2, two grants with no response → data_req_o = 0 while requests are pending. One response routes to the first master's bit; the request reasserts the following cycle.
- Grants to masters 4 then 7, with a response in the same cycle as the second grant → data_r_valid_o = 1<<4, then 1<<7 next response; the count ends at 0.
- data_r_valid_i with the FIFO empty → data_r_valid_o = 0 and the assertion fires.
- Reset pulse with 1 outstanding, then data_r_valid_i → no data_r_valid_o; rr_q = 0 and master 0 wins the first arbitration.
